// File: rtl/riscv_i32_dmem_sequencer_pkg.sv
// Shared definitions for the RV32I data-memory sequencer: access widths, FSM states,
// the per-beat memory request record and small decode helpers.
package riscv_i32_dmem_sequencer_pkg;

   localparam logic [1:0] MW_BYTE = 2'd0;
   localparam logic [1:0] MW_HALF = 2'd1;
   localparam logic [1:0] MW_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_TRAP  = 2'd3
   } t_dmem_state;

   typedef struct packed {
      logic [31:0] address;
      logic [3:0]  byte_enable;
      logic        read_enable;
      logic        write_enable;
      logic [31:0] write_data;
   } t_dmem_beat;

   // Width encodings 2 and 3 both mean a full word.
   function automatic logic [3:0] width_mask(input logic [1:0] width);
      case (width)
         MW_BYTE: width_mask = 4'b0001;
         MW_HALF: width_mask = 4'b0011;
         default: width_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
      is_misaligned = ((width == MW_HALF) && off[0]) ||
                      ((width[1] == 1'b1) && (off != 2'd0));
   endfunction

endpackage

// File: rtl/riscv_i32_dmem_lane_align.sv
// Byte-lane steering for data memory: rotates store data into lanes, and merges,
// rotates back, masks and sign-extends load data from one or two beats.
module riscv_i32_dmem_lane_align
   import riscv_i32_dmem_sequencer_pkg::*;
(
   input  logic [1:0]  wr_off_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] wr_data_o,
   input  logic [1:0]  rd_off_i,
   input  logic [1:0]  rd_width_i,
   input  logic        rd_unsigned_i,
   input  logic [3:0]  rd_lane_sel_i,
   input  logic [31:0] rd_beat0_i,
   input  logic [31:0] rd_beat1_i,
   output logic [31:0] rd_data_o
);

   logic [31:0] merged;
   logic [31:0] rotated;
   logic        sx;

   always_comb begin
      case (wr_off_i)
         2'd1:    wr_data_o = {wr_data_i[23:0], wr_data_i[31:24]};
         2'd2:    wr_data_o = {wr_data_i[15:0], wr_data_i[31:16]};
         2'd3:    wr_data_o = {wr_data_i[7:0],  wr_data_i[31:8]};
         default: wr_data_o = wr_data_i;
      endcase
   end

   // Lanes owned by the first beat come from its data; the rest from the second beat.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = rd_lane_sel_i[i] ? rd_beat0_i[8*i +: 8] : rd_beat1_i[8*i +: 8];
      end
      case (rd_off_i)
         2'd1:    rotated = {merged[7:0],  merged[31:8]};
         2'd2:    rotated = {merged[15:0], merged[31:16]};
         2'd3:    rotated = {merged[23:0], merged[31:24]};
         default: rotated = merged;
      endcase
      sx = ~rd_unsigned_i;
      case (rd_width_i)
         MW_BYTE: rd_data_o = {{24{sx & rotated[7]}},  rotated[7:0]};
         MW_HALF: rd_data_o = {{16{sx & rotated[15]}}, rotated[15:0]};
         default: rd_data_o = rotated;
      endcase
   end

endmodule

// File: rtl/riscv_i32_dmem_sequencer.sv
// RV32I data-memory sequencer: turns one load/store into one or two word-aligned
// beats on a single-ported memory and returns one response per access.
module riscv_i32_dmem_sequencer
   import riscv_i32_dmem_sequencer_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_address,
   input  logic [1:0]  req_width,
   input  logic        req_unsigned,
   input  logic [31:0] req_write_data,
   output logic        mem_valid,
   output logic [31:0] mem_address,
   output logic [3:0]  mem_byte_enable,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   input  logic        mem_ack,
   input  logic [31:0] mem_read_data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_misaligned
);

   t_dmem_state state_q, state_d;
   t_dmem_beat  beat_q, beat_d;
   logic        mem_valid_q, mem_valid_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  width_q, width_d;
   logic        unsigned_q, unsigned_d;
   logic [7:0]  m8_q, m8_d;
   logic        trap_mis_q, trap_mis_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_mis_q, resp_mis_d;

   logic [1:0]  req_off;
   logic [7:0]  req_m8;
   logic        req_noop;
   logic        req_mis;
   logic [31:0] store_rot;
   logic [31:0] beat0_data;
   logic [31:0] load_data;
   logic        finish;

   assign req_off  = req_address[1:0];
   assign req_m8   = {4'b0000, width_mask(req_width)} << req_off;
   assign req_noop = ~req_read & ~req_write;
   assign req_mis  = is_misaligned(req_width, req_off);

   // On a single-beat ack the beat-0 lanes are still on the bus, not yet in rbuf.
   assign beat0_data = (state_q == ST_BEAT0) ? mem_read_data : rbuf_q;

   riscv_i32_dmem_lane_align u_align (
      .wr_off_i      (req_off),
      .wr_data_i     (req_write_data),
      .wr_data_o     (store_rot),
      .rd_off_i      (off_q),
      .rd_width_i    (width_q),
      .rd_unsigned_i (unsigned_q),
      .rd_lane_sel_i (m8_q[3:0]),
      .rd_beat0_i    (beat0_data),
      .rd_beat1_i    (mem_read_data),
      .rd_data_o     (load_data)
   );

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      mem_valid_d  = mem_valid_q;
      off_d        = off_q;
      width_d      = width_q;
      unsigned_d   = unsigned_q;
      m8_d         = m8_q;
      trap_mis_d   = trap_mis_q;
      rbuf_d       = rbuf_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_mis_d   = 1'b0;
      finish       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               off_d      = req_off;
               width_d    = req_width;
               unsigned_d = req_unsigned;
               m8_d       = req_m8;
               if (req_noop) begin
                  state_d    = ST_TRAP;
                  trap_mis_d = 1'b0;
               end else if (req_mis && !ALLOW_MISALIGNED) begin
                  state_d    = ST_TRAP;
                  trap_mis_d = 1'b1;
               end else begin
                  state_d             = ST_BEAT0;
                  mem_valid_d         = 1'b1;
                  beat_d.address      = {req_address[31:2], 2'b00};
                  beat_d.byte_enable  = req_m8[3:0];
                  beat_d.read_enable  = req_read;
                  beat_d.write_enable = req_write & ~req_read;
                  beat_d.write_data   = store_rot;
               end
            end
         end
         ST_BEAT0: begin
            if (mem_ack) begin
               rbuf_d = mem_read_data;
               if (m8_q[7:4] != 4'b0000) begin
                  state_d            = ST_BEAT1;
                  beat_d.address     = beat_q.address + 32'd4;
                  beat_d.byte_enable = m8_q[7:4];
               end else begin
                  finish = 1'b1;
               end
            end
         end
         ST_BEAT1: begin
            if (mem_ack) finish = 1'b1;
         end
         ST_TRAP: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_mis_d   = trap_mis_q;
         end
         default: state_d = ST_IDLE;
      endcase

      if (finish) begin
         state_d      = ST_IDLE;
         mem_valid_d  = 1'b0;
         beat_d       = '0;
         resp_valid_d = 1'b1;
         resp_data_d  = beat_q.read_enable ? load_data : 32'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         mem_valid_q  <= 1'b0;
         off_q        <= '0;
         width_q      <= '0;
         unsigned_q   <= 1'b0;
         m8_q         <= '0;
         trap_mis_q   <= 1'b0;
         rbuf_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_mis_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         mem_valid_q  <= mem_valid_d;
         off_q        <= off_d;
         width_q      <= width_d;
         unsigned_q   <= unsigned_d;
         m8_q         <= m8_d;
         trap_mis_q   <= trap_mis_d;
         rbuf_q       <= rbuf_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_mis_q   <= resp_mis_d;
      end
   end

   assign req_ready        = (state_q == ST_IDLE);
   assign mem_valid        = mem_valid_q;
   assign mem_address      = beat_q.address;
   assign mem_byte_enable  = beat_q.byte_enable;
   assign mem_read_enable  = beat_q.read_enable;
   assign mem_write_enable = beat_q.write_enable;
   assign mem_write_data   = beat_q.write_data;
   assign resp_valid       = resp_valid_q;
   assign resp_data        = resp_data_q;
   assign resp_misaligned  = resp_mis_q;

endmodule
